// File: rtl/mux_nx1_stream_if.sv
// Handshake bundle for mux_nx1_stream: N producer channels in, one consumer out.
// The master modport is the environment side; the slave modport is the mux itself.
interface mux_nx1_stream_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = $clog2(N)
);
    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SEL_W-1:0]     out_chan;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/mux_nx1_stream.sv
// N-to-1 stream multiplexer with fixed or round-robin selection and one registered
// output stage; in_ready is combinational and only ever granted to a single channel.
module mux_nx1_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input logic               clk,
    input logic               rst,
    mux_nx1_stream_if.slave   bus
);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("mux_nx1_stream: N must be in 2..16");
    end
    if (SEL_W != $clog2(N)) begin : g_bad_sel_w
        $error("mux_nx1_stream: SEL_W must equal $clog2(N)");
    end

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load;
    logic             xfer;
    logic             fixed_vld, rr_vld, grant_vld;
    logic [SEL_W-1:0] fixed_idx, rr_idx, grant_idx;
    logic [N-1:0]     in_ready;
    logic [WIDTH-1:0] chan_data [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign chan_data[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    // Out-of-range select yields no grant; index forced to 0 so the data mux stays in range.
    always_comb begin
        fixed_vld = 32'(bus.sel) < N;
        fixed_idx = fixed_vld ? bus.sel : '0;
    end

    // First valid channel starting at ptr_q, wrapping past N-1.
    always_comb begin
        int unsigned cand;
        rr_vld = 1'b0;
        rr_idx = '0;
        cand   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!rr_vld && bus.in_valid[SEL_W'(cand)]) begin
                rr_vld = 1'b1;
                rr_idx = SEL_W'(cand);
            end
        end
    end

    assign grant_vld = bus.mode ? rr_vld : fixed_vld;
    assign grant_idx = bus.mode ? rr_idx : fixed_idx;
    assign load      = !out_valid_q || bus.out_ready;
    assign xfer      = load && grant_vld && bus.in_valid[grant_idx];

    always_comb begin
        in_ready = '0;
        if (!rst && load && grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = chan_data[grant_idx];
            out_chan_d  = grant_idx;
            if (bus.mode) begin
                ptr_d = (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
            end
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_chan  = out_chan_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));

    a_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
        out_valid_q && !bus.out_ready |=> out_valid_q && $stable(out_data_q)
                                          && $stable(out_chan_q));

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Bench for mux_nx1_stream: a reference model predicts grants and in_ready, and a
// scoreboard queue checks every word the output stage hands to the consumer.
module tb_mux_nx1_stream;
    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_nx1_stream_if #(.WIDTH(W), .N(N)) bus_a ();
    mux_nx1_stream_if #(.WIDTH(W), .N(3)) bus_b ();

    mux_nx1_stream #(.WIDTH(W), .N(N)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mux_nx1_stream #(.WIDTH(W), .N(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_vec  = 0;
    int n_bad  = 0;
    int n_pops = 0;

    logic [SW+W-1:0] sb_q[$];
    int              chan_log[$];
    int              m_ptr;
    bit              m_ov;
    bit              last_xfer;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_ov  = 1'b0;
        sb_q.delete();
    endtask

    // Called one time unit after a rising edge with inputs already driven; returns
    // at the same phase of the next cycle.
    task automatic step();
        bit              gv, load;
        int              g;
        logic [N-1:0]    exp_rdy;
        logic [SW+W-1:0] e;
        #1;
        check_eq("out_valid", 32'(bus_a.out_valid), 32'(m_ov));
        load = !m_ov || bus_a.out_ready;
        gv   = 1'b0;
        g    = 0;
        if (!bus_a.mode) begin
            if (bus_a.sel < N) begin
                gv = 1'b1;
                g  = int'(bus_a.sel);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (!gv && bus_a.in_valid[idx]) begin
                    gv = 1'b1;
                    g  = idx;
                end
            end
        end
        exp_rdy = (load && gv) ? (4'b0001 << g) : 4'b0000;
        check_eq("in_ready", 32'(bus_a.in_ready), 32'(exp_rdy));
        if (m_ov) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q[0];
                check_eq("out_data", 32'(bus_a.out_data), 32'(e[W-1:0]));
                check_eq("out_chan", 32'(bus_a.out_chan), 32'(e[W +: SW]));
                if (bus_a.out_ready) begin
                    void'(sb_q.pop_front());
                    chan_log.push_back(int'(bus_a.out_chan));
                    n_pops++;
                end
            end
        end
        last_xfer = load && gv && bus_a.in_valid[g];
        if (last_xfer) begin
            sb_q.push_back({SW'(g), bus_a.in_data[g*W +: W]});
            if (bus_a.mode) m_ptr = (g + 1) % N;
            m_ov = 1'b1;
        end else if (load) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    logic [7:0] words [3];
    int         idx;
    int         pops_before;

    initial begin
        rst             = 1'b1;
        bus_a.mode      = 1'b0;
        bus_a.sel       = '0;
        bus_a.in_data   = '0;
        bus_a.in_valid  = '1;
        bus_a.out_ready = 1'b1;
        bus_b.mode      = 1'b0;
        bus_b.sel       = 2'd3;
        bus_b.in_data   = {8'h33, 8'h22, 8'h11};
        bus_b.in_valid  = 3'b111;
        bus_b.out_ready = 1'b1;
        model_reset();
        #1;
        check_eq("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check_eq("rst_out_data", 32'(bus_a.out_data), 32'd0);
        check_eq("rst_out_chan", 32'(bus_a.out_chan), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus_a.in_valid = '0;

        // Fixed select of channel 2
        bus_a.sel                 = 2'd2;
        bus_a.in_data[2*W +: W]   = 8'hA5;
        bus_a.in_valid            = 4'b0100;
        #1;
        check_eq("fix_in_ready", 32'(bus_a.in_ready), 32'h4);
        step();
        bus_a.in_valid = '0;
        check_eq("fix_out_valid", 32'(bus_a.out_valid), 32'd1);
        check_eq("fix_out_data", 32'(bus_a.out_data), 32'hA5);
        check_eq("fix_out_chan", 32'(bus_a.out_chan), 32'd2);
        step();

        // Stream on channel 1 with a three-cycle consumer stall
        words       = '{8'h10, 8'h11, 8'h12};
        idx         = 0;
        pops_before = n_pops;
        bus_a.sel   = 2'd1;
        for (int c = 0; c < 9; c++) begin
            bus_a.out_ready         = !(c >= 1 && c <= 3);
            bus_a.in_valid          = (idx < 3) ? 4'b0010 : 4'b0000;
            bus_a.in_data           = '0;
            bus_a.in_data[1*W +: W] = words[(idx < 3) ? idx : 2];
            if (c == 2) begin
                check_eq("stall_in_ready", 32'(bus_a.in_ready), 32'd0);
                check_eq("stall_hold", 32'(bus_a.out_data), 32'h10);
            end
            step();
            if (last_xfer) idx++;
        end
        check_eq("stream_words", 32'(n_pops - pops_before), 32'd3);

        // Round-robin, all channels valid
        chan_log.delete();
        bus_a.mode      = 1'b1;
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < N; i++) bus_a.in_data[i*W +: W] = 8'(8'h20 + i);
        bus_a.in_valid = 4'b1111;
        for (int c = 0; c < 6; c++) step();
        bus_a.in_valid = 4'b0000;
        step();
        for (int i = 0; i < 6; i++) begin
            if (i < chan_log.size()) check_eq("rr_seq", 32'(chan_log[i]), 32'(i % 4));
            else check_eq("rr_seq_len", 32'(chan_log.size()), 32'd6);
        end

        // Pointer is now 2; only channels 1 and 3 valid
        chan_log.delete();
        bus_a.in_valid = 4'b1010;
        step();
        step();
        bus_a.in_valid = 4'b0000;
        step();
        check_eq("wrap_len", 32'(chan_log.size()), 32'd2);
        if (chan_log.size() == 2) begin
            check_eq("wrap_first", 32'(chan_log[0]), 32'd3);
            check_eq("wrap_second", 32'(chan_log[1]), 32'd1);
        end
        bus_a.in_valid = 4'b1111;
        #1;
        check_eq("ptr_after_wrap", 32'(bus_a.in_ready), 32'h4);
        step();
        bus_a.in_valid = 4'b0000;
        step();

        // N=3 instance: out-of-range select never grants
        for (int c = 0; c < 3; c++) begin
            check_eq("n3_in_ready", 32'(bus_b.in_ready), 32'd0);
            check_eq("n3_out_valid", 32'(bus_b.out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        bus_b.sel = 2'd2;
        #1;
        check_eq("n3_sel2_ready", 32'(bus_b.in_ready), 32'h4);
        @(posedge clk);
        #1;
        check_eq("n3_out_valid2", 32'(bus_b.out_valid), 32'd1);
        check_eq("n3_out_chan", 32'(bus_b.out_chan), 32'd2);
        check_eq("n3_out_data", 32'(bus_b.out_data), 32'h33);
        bus_b.sel = 2'd3;

        // Random traffic against the model
        for (int c = 0; c < 200; c++) begin
            bus_a.mode      = 1'($urandom_range(0, 1));
            bus_a.sel       = 2'($urandom_range(0, 3));
            bus_a.in_valid  = 4'($urandom_range(0, 15));
            bus_a.out_ready = ($urandom_range(0, 3) != 0);
            bus_a.in_data   = 32'($urandom);
            step();
        end
        bus_a.in_valid  = '0;
        bus_a.out_ready = 1'b1;
        step();
        step();
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset while a word is held under backpressure
        bus_a.mode              = 1'b0;
        bus_a.sel               = 2'd0;
        bus_a.in_data           = '0;
        bus_a.in_data[0 +: W]   = 8'h77;
        bus_a.in_valid          = 4'b0001;
        step();
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 4'b1111;
        #2;
        check_eq("pre_rst_data", 32'(bus_a.out_data), 32'h77);
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check_eq("arst_out_data", 32'(bus_a.out_data), 32'd0);
        check_eq("arst_out_chan", 32'(bus_a.out_chan), 32'd0);
        check_eq("arst_in_ready", 32'(bus_a.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("rst_edge_ready", 32'(bus_a.in_ready), 32'd0);
        rst = 1'b0;
        model_reset();
        bus_a.mode      = 1'b1;
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < N; i++) bus_a.in_data[i*W +: W] = 8'(8'h40 + i);
        step();
        bus_a.in_valid = 4'b0000;
        check_eq("post_rst_chan", 32'(bus_a.out_chan), 32'd0);
        check_eq("post_rst_data", 32'(bus_a.out_data), 32'h40);
        step();
        check_eq("final_sb", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mux_nx1_stream.md
Name: mux_nx1_stream

Overview:
- Parametrised N-to-1, WIDTH-bit channel multiplexer with a valid/ready handshake on every input and on the output.
- Selection mode is chosen at run time: fixed (external select) or round-robin (fair arbitration across valid channels).
- One registered output stage, so the block sits between producer channels and a single shared consumer on a pipelined datapath.
- Next generation of the combinational 2x1/4x1 mux family: adds width and channel-count generality, flow control and arbitration.

Parameters:
- WIDTH, 8, data bits per channel.
- N, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(N), select and channel-index width; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- in_data  input  N*WIDTH  packed input data; channel i occupies [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready (combinational).
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_chan  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0. in_ready is forced to all zeros while rst=1.
- Load enable: load = !out_valid || out_ready.
- Grant g, fixed mode (mode=0): g=sel. If sel>=N there is no grant.
- Grant g, round-robin mode (mode=1): g is the first channel with in_valid=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1. If no channel is valid there is no grant.
- in_ready[i] = load && grant exists && i==g. All other bits are 0. At most one bit is high per cycle.
- Input transfer occurs when in_valid[g] && in_ready[g]. On the next edge: out_data<=in_data[g], out_chan<=g, out_valid<=1.
- Round-robin pointer: on a transfer in mode=1, ptr<=(g+1) mod N, wrapping N-1 -> 0. ptr does not change in mode=0 or when no transfer occurs. ptr is retained across mode switches.
- When load=1 and no transfer occurs: out_valid<=0. out_data and out_chan hold their values.
- Backpressure: when out_valid=1 and out_ready=0, out_data, out_valid and out_chan hold, and in_ready is all zeros.
- Latency is 1 cycle from input transfer to out_valid. Throughput is one word per cycle when out_ready is held high (a simultaneous drain and refill is allowed).
- Selection changes: a sel or mode change takes effect on the same cycle's grant. It never alters a word already held in the output register.
- Reset mid-operation: the held word is discarded, and no in_ready is asserted during reset. The first grant after release starts from ptr=0.
- in_ready may depend on in_valid in round-robin mode only. Producers must not make in_valid depend on in_ready.

Test Plan:
- N=4, WIDTH=8, mode=0, sel=2, ch2 drives 0xA5 valid, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0xA5, out_chan=2, out_valid=1.
- mode=0, sel=1, ch1 drives a stream 0x10,0x11,0x12, out_ready low for 3 cycles after the first word -> out_data holds 0x10, in_ready=0 during the stall. Output then continues 0x11, 0x12 with no loss or duplication.
- mode=1, all four channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1, one word per cycle.
- mode=1, ptr=2, only ch1 and ch3 valid -> grants 3 then 1 (wrap-around). ptr ends at 2.
- N=3 build, mode=0, sel=3 (out of range), all channels valid -> in_ready=0 and out_valid stays 0.
- Assert rst while out_valid=1 and out_ready=0 -> out_valid=0, out_data=0, out_chan=0 immediately without waiting for a clock edge. After release with mode=1 and all valid, the first out_chan is 0.
